// File: rtl/skein_issue_ctrl_if.sv
// Handshake and datapath bundle between the Skein issue controller,
// its requesters, the hash pipeline and the result consumer.
interface skein_issue_ctrl_if #(
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = 2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*1024-1:0] req_msg;
    logic [NREQ-1:0]      req_ready;
    logic [1023:0]        core_msg;
    logic [63:0]          core_hash;
    logic                 res_valid;
    logic                 res_ready;
    logic [63:0]          res_hash;
    logic [ID_W-1:0]      res_id;
    logic [CW-1:0]        inflight;
    logic                 busy;

    modport master (
        output req_valid, req_msg, core_hash, res_ready,
        input  req_ready, core_msg, res_valid, res_hash,
        input  res_id, inflight, busy
    );

    modport slave (
        input  req_valid, req_msg, core_hash, res_ready,
        output req_ready, core_msg, res_valid, res_hash,
        output res_id, inflight, busy
    );
endinterface

// File: rtl/skein_issue_ctrl.sv
// Round-robin issue scheduler and result tracker for the Skein pipeline.
// Optional counters stat_issued/stat_done: define SKEIN_CTRL_STATS_EN.
module skein_issue_ctrl #(
    parameter int NREQ       = 4,
    parameter int LATENCY    = 90,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    skein_issue_ctrl_if.slave bus
`ifdef SKEIN_CTRL_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_done
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [1023:0]               core_msg_q, core_msg_d;
    logic [LATENCY-1:0]          tag_v_q;
    logic [LATENCY-1:0][ID_W-1:0] tag_id_q;
    logic [ID_W+63:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q, inflight_q;

    logic [NREQ-1:0] gnt, ready_w;
    logic [ID_W-1:0] gnt_id;
    logic            found;
    logic [CW:0]     used;
    logic            credit_ok;
    logic            issue, push, pop, res_valid_w;
    logic [ID_W+63:0] head;

    assign used      = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

    // Round-robin search: indices at/after rr_ptr first, then wrap.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i] && ID_W'(i) >= rr_ptr_q) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

    assign ready_w = (credit_ok && rst_n) ? gnt : '0;
    assign issue   = |ready_w;
    assign push    = tag_v_q[LATENCY-1];
    assign pop     = res_valid_w & bus.res_ready;

    // Select the granted message, or a zero bubble when nothing issues.
    always_comb begin
        core_msg_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready_w[i]) core_msg_d = bus.req_msg[i*1024 +: 1024];
        end
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Issue register, pointer, tag line and occupancy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            core_msg_q <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            core_msg_q <= core_msg_d;
            tag_v_q    <= {tag_v_q[LATENCY-2:0], issue};
            tag_id_q   <= {tag_id_q[LATENCY-2:0], gnt_id};
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_q + CW'(push) - CW'(pop);
            inflight_q <= inflight_q + CW'(issue) - CW'(push);
        end
    end

    // Result storage; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {tag_id_q[LATENCY-1], bus.core_hash};
    end

    assign res_valid_w   = count_q != '0;
    assign head          = mem_q[rd_ptr_q];
    assign bus.req_ready = ready_w;
    assign bus.core_msg  = core_msg_q;
    assign bus.res_valid = res_valid_w;
    assign bus.res_hash  = res_valid_w ? head[63:0] : '0;
    assign bus.res_id    = res_valid_w ? head[ID_W+63:64] : '0;
    assign bus.inflight  = inflight_q;
    assign bus.busy      = (inflight_q != '0) | res_valid_w;

`ifdef SKEIN_CTRL_STATS_EN
    logic [31:0] stat_issued_q, stat_done_q;

    // Free-running wrap-around issue and pop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_done_q   <= '0;
        end else begin
            if (issue) stat_issued_q <= stat_issued_q + 32'd1;
            if (pop)   stat_done_q   <= stat_done_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_done   = stat_done_q;
`endif
endmodule
